// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity-mode codes and defaults.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_t;

    // Line value for the parity slot given the XOR of all data bits sent.
    function automatic logic parity_bit(input logic [1:0] mode, input logic xor_acc);
        logic bit_val;
        case (mode)
            PAR_EVEN: bit_val = xor_acc;
            PAR_ODD:  bit_val = ~xor_acc;
            default:  bit_val = 1'b1;
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter fed by a FWFT FIFO; data width, oversampling, parity and
// stop-bit count are configurable, and frames run back-to-back when the FIFO stays non-empty.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
    input  logic                 CLK288MHZ,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] dataIn,
    input  logic                 fifoNE,
    output logic                 readEn,
    input  logic [1:0]           parityMode,
    input  logic                 twoStop,
    output logic                 txBusy,
    output logic                 frameDone,
    output logic                 uart_txd_in
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [1:0]           mode_q, mode_d;
    logic                 two_stop_q, two_stop_d;
    logic                 txd_q, txd_d;
    logic                 read_en_q, read_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic bit_end;
    logic load_ok;
    logic do_load;

    assign bit_end = tick && (tick_cnt_q == TICK_LAST);
    // A pop issued last cycle may not yet be reflected in fifoNE.
    assign load_ok = fifoNE && !read_en_q;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        mode_d     = mode_q;
        two_stop_d = two_stop_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        read_en_d  = 1'b0;
        done_d     = 1'b0;
        do_load    = 1'b0;

        if (tick && (state_q != StIdle)) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (load_ok) do_load = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    parity_d = parity_q ^ shift_q[0];
                    shift_d  = shift_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (mode_q == PAR_NONE) begin
                            state_d = StStop;
                            txd_d   = 1'b1;
                        end else begin
                            state_d = StParity;
                            txd_d   = parity_bit(mode_q, parity_d);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    txd_d   = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    // bit_cnt_q marks which stop bit is in flight.
                    if (two_stop_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BW'(1);
                    end else begin
                        done_d = 1'b1;
                        if (load_ok) begin
                            do_load = 1'b1;
                        end else begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_load) begin
            state_d    = StStart;
            shift_d    = dataIn;
            mode_d     = parityMode;
            two_stop_d = twoStop;
            parity_d   = 1'b0;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            read_en_d  = 1'b1;
            busy_d     = 1'b1;
            txd_d      = 1'b0;
        end
    end

    always_ff @(posedge CLK288MHZ) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            mode_q     <= PAR_NONE;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
            read_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            mode_q     <= mode_d;
            two_stop_q <= two_stop_d;
            txd_q      <= txd_d;
            read_en_q  <= read_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign uart_txd_in = txd_q;
    assign readEn      = read_en_q;
    assign txBusy      = busy_q;
    assign frameDone   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: three parameterisations share a FIFO model and a
// random baud tick; observed line bits per frame are compared against a frame-level model.
module tb_uart_tx_param;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] parity_mode;
    logic       two_stop;

    logic [8:0] fifo_q[$];
    logic [8:0] push_q[$];
    logic       fifo_ne = 1'b0;
    logic [8:0] fifo_head = '0;
    logic       pop_now;

    int sel;
    int cur_bits;
    int cur_os;
    int n_checks = 0;
    int n_pass = 0;

    logic ne_a, ne_b, ne_c;
    logic re_a, re_b, re_c, busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c, txd_a, txd_b, txd_c;
    logic re_m, busy_m, done_m, txd_m;

    always #5 clk = ~clk;

    assign ne_a = fifo_ne && (sel == 0);
    assign ne_b = fifo_ne && (sel == 1);
    assign ne_c = fifo_ne && (sel == 2);

    always_comb begin
        re_m = re_a; busy_m = busy_a; done_m = done_a; txd_m = txd_a;
        if (sel == 1) begin
            re_m = re_b; busy_m = busy_b; done_m = done_b; txd_m = txd_b;
        end else if (sel == 2) begin
            re_m = re_c; busy_m = busy_c; done_m = done_c; txd_m = txd_c;
        end
    end

    uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16)) u_a (
        .CLK288MHZ(clk), .reset(reset), .tick(tick), .dataIn(fifo_head[7:0]), .fifoNE(ne_a),
        .readEn(re_a), .parityMode(parity_mode), .twoStop(two_stop), .txBusy(busy_a),
        .frameDone(done_a), .uart_txd_in(txd_a)
    );
    uart_tx_param #(.DATA_BITS(5), .OVERSAMPLE(4)) u_b (
        .CLK288MHZ(clk), .reset(reset), .tick(tick), .dataIn(fifo_head[4:0]), .fifoNE(ne_b),
        .readEn(re_b), .parityMode(parity_mode), .twoStop(two_stop), .txBusy(busy_b),
        .frameDone(done_b), .uart_txd_in(txd_b)
    );
    uart_tx_param #(.DATA_BITS(9), .OVERSAMPLE(16)) u_c (
        .CLK288MHZ(clk), .reset(reset), .tick(tick), .dataIn(fifo_head), .fifoNE(ne_c),
        .readEn(re_c), .parityMode(parity_mode), .twoStop(two_stop), .txBusy(busy_c),
        .frameDone(done_c), .uart_txd_in(txd_c)
    );

    // Random single-cycle baud ticks, never two in a row.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick) tick = 1'b0;
            else tick = ($urandom_range(0, 2) == 0);
        end
    end

    // FWFT FIFO: a pop seen during a cycle takes effect just after that cycle's closing edge.
    always begin
        @(negedge clk);
        pop_now = re_m;
        @(posedge clk);
        #1;
        if (pop_now && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
        while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
        fifo_ne   = (fifo_q.size() > 0);
        fifo_head = fifo_ne ? fifo_q[0] : '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic use_dut(input int s);
        sel = s;
        cur_bits = (s == 1) ? 5 : (s == 2) ? 9 : 8;
        cur_os   = (s == 1) ? 4 : 16;
    endtask

    // Frame as a list of line bits, index 0 = start bit.
    function automatic logic [15:0] exp_frame(input logic [8:0] d, input int nb,
                                              input logic [1:0] m, input logic ts,
                                              output int nbits);
        logic [15:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < nb; i++) begin
            f[i + 1] = d[i];
            ones += int'(d[i]);
        end
        nbits = nb + 1;
        if (m != 2'b00) begin
            f[nbits] = (m == 2'b01) ? (ones % 2 == 1) : (m == 2'b10) ? (ones % 2 == 0) : 1'b1;
            nbits++;
        end
        f[nbits] = 1'b1;
        nbits++;
        if (ts) begin
            f[nbits] = 1'b1;
            nbits++;
        end
        return f;
    endfunction

    task automatic frame(input logic [8:0] d, input logic [1:0] m, input logic ts, input bit more,
                         input int chg_at, input logic [1:0] chg_mode, input string tag);
        int nbits, nticks, t, w, cyc, re_n, done_n, busy_low, idx;
        logic [15:0] expv, obs;
        expv = exp_frame(d, cur_bits, m, ts, nbits);
        nticks = nbits * cur_os;
        w = 0;
        while ((re_m !== 1'b1) && (w < 10)) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_start"}, 32'(re_m), 32'd1);
        if (re_m !== 1'b1) return;
        obs = '0; t = 0; cyc = 0; re_n = 0; done_n = 0; busy_low = 0;
        while ((t < nticks) && (cyc < 20000)) begin
            if (re_m) re_n++;
            if (done_m && (cyc > 0)) done_n++;
            if (!busy_m) busy_low++;
            if (tick) begin
                idx = t / cur_os;
                if (t % cur_os == 0) obs[idx] = txd_m;
                else if (obs[idx] !== txd_m) obs[idx] = 1'bx;
                t++;
                if (t == chg_at) parity_mode = chg_mode;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_bits"}, 32'(obs), 32'(expv));
        check({tag, "_pulses"}, {re_n[7:0], done_n[7:0], busy_low[7:0], 7'd0, done_m},
              {8'd1, 8'd0, 8'd0, 8'd1});
        if (more) check({tag, "_next"}, {29'd0, re_m, busy_m, txd_m}, 32'b110);
        else check({tag, "_end"}, {29'd0, re_m, busy_m, txd_m}, 32'b001);
    endtask

    task automatic rand_frames(input int n, input string tag);
        logic [8:0] d;
        logic [1:0] m;
        logic ts;
        for (int i = 0; i < n; i++) begin
            d  = 9'($urandom) & 9'((1 << cur_bits) - 1);
            m  = 2'($urandom_range(0, 3));
            ts = 1'($urandom_range(0, 1));
            parity_mode = m;
            two_stop = ts;
            push_q.push_back(d);
            @(negedge clk);
            frame(d, m, ts, 1'b0, 0, PAR_NONE, $sformatf("%s%0d", tag, i));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    initial begin
        int t, cyc, w;
        reset = 1'b1;
        parity_mode = PAR_NONE;
        two_stop = 1'b0;
        use_dut(0);
        repeat (3) @(negedge clk);
        check("reset_state", {20'd0, txd_a, re_a, busy_a, done_a, txd_b, re_b, busy_b, done_b,
              txd_c, re_c, busy_c, done_c}, {20'd0, 12'b1000_1000_1000});
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // 8N1 basic and parity variants
        push_q.push_back(9'h0A5);
        frame(9'h0A5, PAR_NONE, 1'b0, 1'b0, 0, PAR_NONE, "8n1");
        parity_mode = PAR_EVEN; push_q.push_back(9'h0A5);
        frame(9'h0A5, PAR_EVEN, 1'b0, 1'b0, 0, PAR_NONE, "a5_even");
        parity_mode = PAR_ODD; push_q.push_back(9'h0A5);
        frame(9'h0A5, PAR_ODD, 1'b0, 1'b0, 0, PAR_NONE, "a5_odd");
        parity_mode = PAR_MARK; push_q.push_back(9'h0A5);
        frame(9'h0A5, PAR_MARK, 1'b0, 1'b0, 0, PAR_NONE, "a5_mark");
        parity_mode = PAR_EVEN; push_q.push_back(9'h007);
        frame(9'h007, PAR_EVEN, 1'b0, 1'b0, 0, PAR_NONE, "07_even");

        // Back-to-back 8E2
        two_stop = 1'b1;
        push_q.push_back(9'h055);
        push_q.push_back(9'h00F);
        frame(9'h055, PAR_EVEN, 1'b1, 1'b1, 0, PAR_NONE, "b2b_1");
        frame(9'h00F, PAR_EVEN, 1'b1, 1'b0, 0, PAR_NONE, "b2b_2");
        check("b2b_fifo_empty", 32'(fifo_q.size() + push_q.size()), 32'd0);

        // Config change during DATA only affects the following frame
        two_stop = 1'b0;
        parity_mode = PAR_NONE;
        push_q.push_back(9'h03C);
        push_q.push_back(9'h0C3);
        frame(9'h03C, PAR_NONE, 1'b0, 1'b1, 4 * cur_os, PAR_EVEN, "cfg_1");
        frame(9'h0C3, PAR_EVEN, 1'b0, 1'b0, 0, PAR_NONE, "cfg_2");

        rand_frames(5, "rnd_a");

        // Reset during data bit 3
        parity_mode = PAR_NONE;
        two_stop = 1'b0;
        push_q.push_back(9'h0F0);
        push_q.push_back(9'h03C);
        w = 0;
        while ((re_m !== 1'b1) && (w < 10)) begin
            @(negedge clk);
            w++;
        end
        t = 0;
        cyc = 0;
        while ((t < 4 * cur_os) && (cyc < 5000)) begin
            if (tick) t++;
            @(negedge clk);
            cyc++;
        end
        check("rst_pre_bit3", 32'(txd_m), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_line", {28'd0, txd_m, busy_m, re_m, done_m}, 32'b1000);
        @(negedge clk);
        check("rst_hold", {28'd0, txd_m, busy_m, re_m, done_m}, 32'b1000);
        reset = 1'b0;
        frame(9'h03C, PAR_NONE, 1'b0, 1'b0, 0, PAR_NONE, "after_rst");
        check("rst_fifo_empty", 32'(fifo_q.size() + push_q.size()), 32'd0);

        // DATA_BITS=5, OVERSAMPLE=4
        use_dut(1);
        parity_mode = PAR_ODD;
        push_q.push_back(9'h01B);
        frame(9'h01B, PAR_ODD, 1'b0, 1'b0, 0, PAR_NONE, "w5_1b_odd");
        rand_frames(3, "rnd_b");

        // DATA_BITS=9
        use_dut(2);
        parity_mode = PAR_NONE;
        two_stop = 1'b0;
        push_q.push_back(9'h1FF);
        frame(9'h1FF, PAR_NONE, 1'b0, 1'b0, 0, PAR_NONE, "w9_1ff");
        rand_frames(2, "rnd_c");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter that replaces the fixed 8-bit, even-parity transmitter. It supports a configurable data width, oversampling ratio, per-frame parity mode and per-frame stop-bit count, and sends frames back-to-back with no idle gap. It sits between a first-word-fall-through (FWFT) TX FIFO and the `uart_txd_in` pin. It is driven by the shared baud `tick` enable in the CLK288MHZ domain.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `OVERSAMPLE`, default 16: ticks per bit period, legal range 4..64.
- Clock and reset: reset `reset`, synchronous, active-high; clock `CLK288MHZ`.
- `CLK288MHZ` in 1: system clock.
- `reset` in 1: synchronous active-high reset.
- `tick` in 1: baud enable, single-cycle pulse at OVERSAMPLE × baud rate.
- `dataIn` in DATA_BITS: FIFO head word, valid whenever `fifoNE`=1 (FWFT).
- `fifoNE` in 1: FIFO not empty.
- `readEn` out 1: FIFO pop, one-cycle pulse per word.
- `parityMode` in 2: 00 none, 01 even, 10 odd, 11 mark (parity bit always 1).
- `twoStop` in 1: 0 means one stop bit, 1 means two stop bits.
- `txBusy` out 1: high from frame start until the last stop bit completes.
- `frameDone` out 1: one-cycle pulse at the end of each frame's stop period.
- `uart_txd_in` out 1: serial line, idle high.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- **Reset values:** `uart_txd_in`=1, `readEn`=0, `txBusy`=0, `frameDone`=0, state IDLE. All counters and the shift register are 0.
- **Frame load, IDLE → START.** Occurs when `fifoNE`=1 and `readEn`=0.
  - Latch `dataIn` into the shift register.
  - Latch `parityMode` and `twoStop`.
  - Clear the tick and bit counters.
  - Assert `readEn` for exactly one cycle.
  - The `readEn` guard prevents a double pop while `fifoNE` updates.
- **Config stability:** config inputs are sampled only at frame load. Changing them mid-frame has no effect on the current frame.
- **START:** line = 0 for OVERSAMPLE ticks, then go to DATA.
- **DATA:** LSB first, DATA_BITS bits, each held for OVERSAMPLE ticks.
  - Shift right on each bit boundary.
  - Accumulate XOR parity from the bits as they are sent.
- **DATA exit:** after the last data bit, go to PARITY if the latched mode ≠ 00, else go to STOP.
- **PARITY:** one bit period.
  - Even mode sends the XOR of the data bits.
  - Odd mode sends its complement.
  - Mark mode sends 1.
- **STOP:** line = 1 for one bit period, or two if `twoStop` was latched. Pulse `frameDone` on the final tick.
  - If `fifoNE`=1 and `readEn`=0 at that cycle, perform a frame load and go directly to START, so the next start bit follows with zero gap.
  - Otherwise go to IDLE.
- **`tick` ignored in IDLE.** A `tick` arriving in IDLE has no effect. The start bit begins on a fresh tick count.
- **Counter widths:**
  - Tick counter is $clog2(OVERSAMPLE) bits and wraps on terminal count OVERSAMPLE-1.
  - Bit counter is $clog2(DATA_BITS+1) bits. No other arithmetic is used.
- **Reset mid-frame:** the line returns high on the next cycle and no `readEn` is issued. The word already popped for that frame is discarded. This loss is intended and is documented for software.

## Timing
- **Start latency:** `readEn` and the `uart_txd_in` falling edge both occur 1 cycle after the load condition is seen.
- **Bit boundaries:** the line changes 1 cycle after the `tick` that completes a bit period. All outputs are registered.
- **Frame length** is OVERSAMPLE × (1 + DATA_BITS + P + S) ticks, where P ∈ {0,1} and S ∈ {1,2}.
- **`txBusy`** rises with the start bit. It falls 1 cycle after the final stop tick unless a back-to-back load occurs.
- **`readEn`** is never high on two consecutive cycles.
- **`frameDone`** coincides with the stop-to-next-state transition.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`, `PAR_MARK`;
  - `UART_OVERSAMPLE_DEFAULT`.
- Single module, no sub-modules. Tick generation stays in the existing external baud generator.
- Two-process style: one registered block plus one next-state block.

## Test plan
- **8N1 basic:** DATA_BITS=8, mode 00, `twoStop`=0, `dataIn`=0xA5 → line reads 0, then 1,0,1,0,0,1,0,1, then 1. 160 ticks total. One `readEn`, one `frameDone`.
- **Parity variants:** 0xA5 with mode 01 → parity bit 0. Mode 10 → 1. Mode 11 → 1. 0x07 with mode 01 → parity bit 1.
- **Back-to-back:** FIFO holds 0x55 and 0x0F, config 8E2 → 2 × 192 ticks with no idle high between the second stop bit and the next start bit. Exactly 2 `readEn` pulses, each 1 cycle wide. `txBusy` stays high throughout.
- **Width/oversample sweep:** DATA_BITS=5, OVERSAMPLE=4, `dataIn`=0x1B, mode 10 → bits 1,1,0,1,1, parity 1, frame length 32 ticks. DATA_BITS=9, 0x1FF, 8N1-style config → 9 ones, frame length 176 ticks at OVERSAMPLE=16.
- **Config change mid-frame:** switch `parityMode` from 00 to 01 during DATA → current frame has no parity bit, next frame does.
- **Reset mid-frame:** assert `reset` at data bit 3 → next cycle the line is 1, `txBusy`=0, no `readEn`. After release with `fifoNE`=1, a clean new frame starts.
